// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable pulse-train generator with start/busy/done handshake
// Optional abort input enabled by defining PTG_ABORT_EN.
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
`ifdef PTG_ABORT_EN
    input  logic             abort,
`endif
    output logic             data,
    output logic             edge_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic [CNT_W-1:0] low_len_q, low_len_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [NUM_W-1:0] pulse_q, pulse_d;
    logic             data_q, data_d;
    logic             edge_out_q, edge_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            high_len_q <= '0;
            low_len_q  <= '0;
            num_q      <= '0;
            phase_q    <= '0;
            pulse_q    <= '0;
            data_q     <= 1'b0;
            edge_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            num_q      <= num_d;
            phase_q    <= phase_d;
            pulse_q    <= pulse_d;
            data_q     <= data_d;
            edge_out_q <= edge_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        num_d      = num_q;
        phase_d    = phase_q;
        pulse_d    = pulse_q;
        abort_hit  = 1'b0;
`ifdef PTG_ABORT_EN
        abort_hit  = abort && ((state_q == S_HIGH) || (state_q == S_LOW));
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Zero lengths are stretched to one cycle so every phase is visible
                    high_len_d = (high_len == '0) ? CNT_W'(1) : high_len;
                    low_len_d  = (low_len == '0) ? CNT_W'(1) : low_len;
                    num_d      = num_pulses;
                    phase_d    = CNT_W'(1);
                    pulse_d    = '0;
                    state_d    = (num_pulses == '0) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_q == high_len_q) begin
                    phase_d = CNT_W'(1);
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_LOW: begin
                if (phase_q == low_len_q) begin
                    phase_d = CNT_W'(1);
                    pulse_d = pulse_q + 1'b1;
                    // pulse_q never exceeds num_q-1 here, so the increment cannot wrap
                    state_d = ((pulse_q + 1'b1) == num_q) ? S_DONE : S_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = S_DONE;
        end

        // Outputs are registered from the next state so they line up with it
        data_d     = (state_d == S_HIGH);
        edge_out_d = (state_d == S_HIGH) && (state_q != S_HIGH);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    assign data     = data_q;
    assign edge_out = edge_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - self-checking bench for pulse_train_gen
// Abort scenario compiled in when PTG_ABORT_EN is defined.
module tb_pulse_train_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] num_pulses;
`ifdef PTG_ABORT_EN
    logic       abort;
`endif
    logic       data;
    logic       edge_out;
    logic       busy;
    logic       done;
    logic [3:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign obs = {data, edge_out, busy, done};

    pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
`ifdef PTG_ABORT_EN
        .abort      (abort),
`endif
        .data       (data),
        .edge_out   (edge_out),
        .busy       (busy),
        .done       (done)
    );

    // Expected {data, edge_out, busy, done} in cycle t after the edge that accepted start.
    function automatic logic [3:0] exp_vec(int h, int l, int n, int t);
        int hh;
        int ll;
        int per;
        int total;
        int w;
        hh    = (h == 0) ? 1 : h;
        ll    = (l == 0) ? 1 : l;
        per   = hh + ll;
        total = n * per;
        if (t >= 1 && t <= total) begin
            w = (t - 1) % per;
            return {(w < hh), (w == 0), 1'b1, 1'b0};
        end
        if (t == total + 1) return 4'b0011;
        return 4'b0000;
    endfunction

    function automatic int burst_len(int h, int l, int n);
        return n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l));
    endfunction

    task automatic launch(int h, int l, int n);
        high_len   = 8'(h);
        low_len    = 8'(l);
        num_pulses = 8'(n);
        start      = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want 0000", obs);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %b want 0000", c, obs);
            end
        end
    endtask

    task automatic test_basic;
        launch(2, 3, 3);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(2, 3, 3, c)) begin
                n_fail++;
                $display("FAIL basic c%0d: got %b want %b", c, obs, exp_vec(2, 3, 3, c));
            end
        end
    endtask

    task automatic test_zero;
        launch(5, 7, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(5, 7, 0, c)) begin
                n_fail++;
                $display("FAIL zero_pulses c%0d: got %b want %b", c, obs, exp_vec(5, 7, 0, c));
            end
        end
        launch(0, 0, 2);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(0, 0, 2, c)) begin
                n_fail++;
                $display("FAIL zero_len c%0d: got %b want %b", c, obs, exp_vec(0, 0, 2, c));
            end
        end
    endtask

    task automatic test_start_while_busy;
        launch(1, 1, 2);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            n_checks++;
            if (c <= 6) begin
                if (obs !== exp_vec(1, 1, 2, c)) begin
                    n_fail++;
                    $display("FAIL busy_start c%0d: got %b want %b", c, obs, exp_vec(1, 1, 2, c));
                end
            end else if (obs !== exp_vec(3, 2, 1, c - 6)) begin
                n_fail++;
                $display("FAIL busy_restart c%0d: got %b want %b", c, obs, exp_vec(3, 2, 1, c - 6));
            end
            if (c == 2) begin
                high_len   = 8'd3;
                low_len    = 8'd2;
                num_pulses = 8'd1;
            end
            if (c == 7) start = 1'b0;
        end
    endtask

    task automatic test_random;
        int h, l, n, total;
        repeat (10) begin
            h = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            n = $urandom_range(0, 5);
            total = burst_len(h, l, n);
            launch(h, l, n);
            for (int c = 1; c <= total + 3; c++) begin
                @(negedge clock);
                n_checks++;
                if (obs !== exp_vec(h, l, n, c)) begin
                    n_fail++;
                    $display("FAIL random h%0d l%0d n%0d c%0d: got %b want %b",
                             h, l, n, c, obs, exp_vec(h, l, n, c));
                end
                high_len   = 8'($urandom);
                low_len    = 8'($urandom);
                num_pulses = 8'($urandom);
                start      = (c <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    task automatic test_max;
        launch(255, 255, 2);
        for (int c = 1; c <= 1023; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(255, 255, 2, c)) begin
                n_fail++;
                $display("FAIL max_len c%0d: got %b want %b", c, obs, exp_vec(255, 255, 2, c));
            end
        end
        launch(1, 1, 255);
        for (int c = 1; c <= 512; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(1, 1, 255, c)) begin
                n_fail++;
                $display("FAIL max_num c%0d: got %b want %b", c, obs, exp_vec(1, 1, 255, c));
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        launch(4, 4, 5);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(4, 4, 5, c)) begin
                n_fail++;
                $display("FAIL midreset_pre c%0d: got %b want %b", c, obs, exp_vec(4, 4, 5, c));
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_async: got %b want 0000", obs);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL midreset_idle c%0d: got %b want 0000", c, obs);
            end
        end
        launch(3, 2, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_vec(3, 2, 1, c)) begin
                n_fail++;
                $display("FAIL midreset_after c%0d: got %b want %b", c, obs, exp_vec(3, 2, 1, c));
            end
        end
    endtask

`ifdef PTG_ABORT_EN
    task automatic test_abort;
        logic [3:0] want;
        launch(5, 5, 4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c <= 3) want = exp_vec(5, 5, 4, c);
            else if (c == 4) want = 4'b0011;
            else want = 4'b0000;
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL abort c%0d: got %b want %b", c, obs, want);
            end
            // held through DONE and IDLE, where it must be ignored
            if (c == 3) abort = 1'b1;
            if (c == 6) abort = 1'b0;
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        high_len   = '0;
        low_len    = '0;
        num_pulses = '0;
`ifdef PTG_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_basic();
        test_zero();
        test_start_while_busy();
        test_random();
        test_max();
        test_reset_mid_burst();
`ifdef PTG_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
